// File: rtl/merge_sort_pkg.sv
// Shared constants and types for the merge-sort scheduler and its datapath.
package merge_sort_pkg;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned ELEMS    = NUM_ROWS * ROW_W;
  localparam int unsigned ROW_IW   = $clog2(NUM_ROWS);
  localparam int unsigned POP_IW   = $clog2(ELEMS);

  typedef logic [ROW_IW-1:0] row_idx_t;
  typedef logic [POP_IW-1:0] pop_idx_t;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_FILL = 1'b1
  } load_state_t;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_INIT  = 2'd1,
    M_DRAIN = 2'd2
  } merge_state_t;

endpackage

// File: rtl/merge_sort_drain_ctrl.sv
// Merge drain sequencer: walks one full bank through ELEMS pops with
// downstream backpressure and hands the bank back on the last handshake.
module merge_sort_drain_ctrl
  import merge_sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        full,
  input  logic              out_ready,
  output logic              mrg_bank,
  output logic              mrg_start,
  output logic              pop_en,
  output logic [POP_IW-1:0] pop_cnt,
  output logic              out_valid,
  output logic              out_last,
  output logic              free,
  output logic              active
);

  localparam pop_idx_t LAST_POP = pop_idx_t'(ELEMS - 1);

  merge_state_t state, state_nxt;
  logic         all_issued;
  logic         hs;

  assign hs     = out_valid && out_ready;
  assign active = (state != M_IDLE);

  // Merge state register
  always_ff @(posedge clk) begin
    if (rst) state <= M_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle strobes; pops stop once the output register is stalled
  always_comb begin
    state_nxt = state;
    mrg_start = 1'b0;
    pop_en    = 1'b0;
    free      = 1'b0;
    case (state)
      M_IDLE:  if (full[mrg_bank]) state_nxt = M_INIT;
      M_INIT: begin
        mrg_start = 1'b1;
        state_nxt = M_DRAIN;
      end
      M_DRAIN: begin
        pop_en = !all_issued && (!out_valid || out_ready);
        if (hs && out_last) begin
          free      = 1'b1;
          state_nxt = M_IDLE;
        end
      end
      default: state_nxt = M_IDLE;
    endcase
    if (rst) begin
      mrg_start = 1'b0;
      pop_en    = 1'b0;
      free      = 1'b0;
    end
  end

  // Pop counter (saturates at the last index), output valid/last and bank pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      mrg_bank   <= 1'b0;
      pop_cnt    <= '0;
      all_issued <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (state == M_INIT) begin
        pop_cnt    <= '0;
        all_issued <= 1'b0;
      end
      if (pop_en) begin
        if (pop_cnt == LAST_POP) all_issued <= 1'b1;
        else                     pop_cnt    <= pop_cnt + pop_idx_t'(1);
        out_valid <= 1'b1;
        out_last  <= (pop_cnt == LAST_POP);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (free) begin
        mrg_bank   <= ~mrg_bank;
        pop_cnt    <= '0;
        all_issued <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/merge_sort_sched.sv
// Frame scheduler: loads rows into ping-pong banks and drains full banks in order.
module merge_sort_sched
  import merge_sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ROW_IW-1:0] wr_row,
  output logic              wr_bank,
  output logic              mrg_bank,
  output logic              mrg_start,
  output logic              pop_en,
  output logic [POP_IW-1:0] pop_cnt,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              busy
);

  localparam row_idx_t LAST_ROW = row_idx_t'(NUM_ROWS - 1);

  load_state_t state, state_nxt;
  row_idx_t    row_cnt, row_nxt, row_sel;
  logic [1:0]  full, full_nxt;
  logic        accept, set_full, err_nxt, free, mrg_active;

  assign in_ready = !rst && !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_row   = row_sel;
  assign busy     = (|full) || mrg_active;

  // Load state register
  always_ff @(posedge clk) begin
    if (rst) state <= L_IDLE;
    else     state <= state_nxt;
  end

  // Next state, write strobe and target row; blk_in mid-frame restarts at row 0
  always_comb begin
    state_nxt = state;
    row_nxt   = row_cnt;
    row_sel   = row_cnt;
    wr_en     = 1'b0;
    err_nxt   = 1'b0;
    set_full  = 1'b0;
    if (accept) begin
      case (state)
        L_IDLE: begin
          if (blk_in) begin
            wr_en     = 1'b1;
            row_sel   = '0;
            row_nxt   = row_idx_t'(1);
            state_nxt = L_FILL;
          end else begin
            err_nxt = 1'b1;
          end
        end
        L_FILL: begin
          wr_en = 1'b1;
          if (blk_in) begin
            err_nxt = 1'b1;
            row_sel = '0;
            row_nxt = row_idx_t'(1);
          end else begin
            row_nxt = row_cnt + row_idx_t'(1);
          end
        end
        default: state_nxt = L_IDLE;
      endcase
    end
    if (wr_en && (row_sel == LAST_ROW)) begin
      set_full  = 1'b1;
      row_nxt   = '0;
      state_nxt = L_IDLE;
    end
    if (rst) row_sel = '0;
  end

  // Bank flags: load sets and drain clears, both may land in the same cycle
  always_comb begin
    full_nxt = full;
    if (free)     full_nxt[mrg_bank] = 1'b0;
    if (set_full) full_nxt[wr_bank]  = 1'b1;
  end

  // Load-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      full      <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      row_cnt   <= row_nxt;
      full      <= full_nxt;
      frame_err <= err_nxt;
      if (set_full) wr_bank <= ~wr_bank;
    end
  end

  merge_sort_drain_ctrl u_drain (
    .clk       (clk),
    .rst       (rst),
    .full      (full),
    .out_ready (out_ready),
    .mrg_bank  (mrg_bank),
    .mrg_start (mrg_start),
    .pop_en    (pop_en),
    .pop_cnt   (pop_cnt),
    .out_valid (out_valid),
    .out_last  (out_last),
    .free      (free),
    .active    (mrg_active)
  );

endmodule

// File: tb/tb_merge_sort_sched.sv
// Scoreboard bench for merge_sort_sched: expected pops/outputs are queued when
// a frame's last row is accepted and retired as the DUT pops and hands off.
module tb_merge_sort_sched;
  import merge_sort_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blk_in = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, wr_en, wr_bank, mrg_bank, mrg_start, pop_en;
  logic out_valid, out_last, frame_err, busy;
  logic [ROW_IW-1:0] wr_row;
  logic [POP_IW-1:0] pop_cnt;

  always #5 clk = ~clk;

  merge_sort_sched dut (
    .clk(clk), .rst(rst), .blk_in(blk_in), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_bank(wr_bank), .mrg_bank(mrg_bank),
    .mrg_start(mrg_start), .pop_en(pop_en), .pop_cnt(pop_cnt), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    int idx;
    int last;
    int bank;
  } exp_t;

  exp_t pop_q[$];
  exp_t out_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tb_bank = 0;
  int n_valid, n_hs, n_last, n_err;
  int mrg_start_cyc, first_pop_cyc, first_valid_cyc, last_cyc, last_beat_cyc;
  bit bp = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_valid = 1'b0;
  int prev_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_hs = 0; n_last = 0; n_err = 0;
    mrg_start_cyc = -1; first_pop_cyc = -1; first_valid_cyc = -1;
    last_cyc = -1; last_beat_cyc = -1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < int'(ELEMS); i++) begin
      exp_t e;
      e.idx  = i;
      e.last = (i == int'(ELEMS) - 1) ? 1 : 0;
      e.bank = tb_bank;
      pop_q.push_back(e);
      out_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at a negedge after the beat is accepted
  task automatic send_beat(input bit blk, input bit exp_wr, input int exp_row,
                           input int gap, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    blk_in   = blk;
    for (int w = 0; w < 300 && !got; w++) begin
      #4;
      if (in_ready) begin
        got = 1'b1;
        acc = cyc;
        check("wr_en", int'(wr_en), int'(exp_wr));
        if (exp_wr) begin
          check("wr_row", int'(wr_row), exp_row);
          check("wr_bank", int'(wr_bank), tb_bank);
          if (exp_row == int'(NUM_ROWS) - 1) begin
            push_frame();
            tb_bank ^= 1;
            last_beat_cyc = cyc;
          end
        end
      end
      @(negedge clk);
    end
    if (!got) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    blk_in   = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    int acc;
    for (int r = 0; r < int'(NUM_ROWS); r++)
      send_beat(r == 0, 1'b1, r, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, acc);
  endtask

  task automatic wait_drain();
    for (int w = 0; w < 2000 && (out_q.size() != 0 || pop_q.size() != 0); w++) @(negedge clk);
    check("drain_timeout", out_q.size() + pop_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Downstream ready: either always ready or the 1,0,0,1 backpressure pattern
  initial begin : ready_drv
    bit [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(negedge clk);
      if (bp) begin
        out_ready = pat[k % 4];
        k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor, sampled one time unit before each rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_last", int'(out_last), prev_last);
        end
        if (out_valid && !out_ready) check("no_pop_while_stalled", int'(pop_en), 0);
        if (pop_en) begin
          if (pop_q.size() == 0) begin
            check("pop_unexpected", 1, 0);
          end else begin
            e = pop_q.pop_front();
            check("pop_cnt", int'(pop_cnt), e.idx);
            check("mrg_bank", int'(mrg_bank), e.bank);
            if (e.idx == 0) first_pop_cyc = cyc;
          end
        end
        if (mrg_start) mrg_start_cyc = cyc;
        if (out_valid) n_valid++;
        if (out_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          n_hs++;
          if (out_q.size() == 0) begin
            check("out_unexpected", 1, 0);
          end else begin
            e = out_q.pop_front();
            check("out_last", int'(out_last), e.last);
          end
          if (out_last) begin
            n_last++;
            last_cyc = cyc;
          end
        end
        if (frame_err) n_err++;
        prev_stall = out_valid && !out_ready;
        prev_valid = out_valid;
        prev_last  = int'(out_last);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, a3, hit;
    clear_stats();

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    check("reset_outs", int'({in_ready, wr_en, wr_row, wr_bank, mrg_bank, mrg_start, pop_en,
                              pop_cnt, out_valid, out_last, frame_err, busy}), 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("in_ready_after_rst", int'(in_ready), 1);
    @(negedge clk);

    // Single contiguous frame, always ready
    clear_stats();
    send_frame(0);
    wait_drain();
    check("t1_start_lat", mrg_start_cyc - last_beat_cyc, 2);
    check("t1_pop_lat", first_pop_cyc - last_beat_cyc, 3);
    check("t1_valid_lat", first_valid_cyc - last_beat_cyc, 4);
    check("t1_valid_cycles", n_valid, 32);
    check("t1_contiguous", last_cyc - first_valid_cyc, 31);
    check("t1_handshakes", n_hs, 32);
    check("t1_lasts", n_last, 1);
    check("t1_busy_after", int'(busy), 0);
    check("t1_no_err", n_err, 0);

    // Three back-to-back frames; third waits for the first drain to free its bank
    clear_stats();
    a3 = -1;
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
        send_beat(r == 0, 1'b1, r, 0, acc);
        if (f == 2 && r == 0) begin
          a3 = acc;
          check("t2_inready_release", a3 - last_cyc, 1);
          check("t2_lasts_at_release", n_last, 1);
        end
      end
    wait_drain();
    check("t2_handshakes", n_hs, 96);
    check("t2_lasts", n_last, 3);

    // Backpressure 1,0,0,1
    clear_stats();
    bp = 1'b1;
    send_frame(0);
    wait_drain();
    bp = 1'b0;
    check("t3_handshakes", n_hs, 32);
    check("t3_lasts", n_last, 1);

    // Protocol errors: stray beat in idle, then restart after row 4
    clear_stats();
    send_beat(1'b0, 1'b0, 0, 0, acc);
    send_beat(1'b1, 1'b1, 0, 0, acc);
    for (int r = 1; r <= 4; r++) send_beat(1'b0, 1'b1, r, 0, acc);
    send_beat(1'b1, 1'b1, 0, 0, acc);
    for (int r = 1; r < int'(NUM_ROWS); r++) send_beat(1'b0, 1'b1, r, 0, acc);
    wait_drain();
    check("t4_err_pulses", n_err, 2);
    check("t4_handshakes", n_hs, 32);
    check("t4_lasts", n_last, 1);

    // Input gaps of 0-3 cycles
    clear_stats();
    send_frame(3);
    wait_drain();
    check("t5_start_lat", mrg_start_cyc - last_beat_cyc, 2);
    check("t5_handshakes", n_hs, 32);

    // Reset in the middle of a drain
    clear_stats();
    send_frame(0);
    hit = 0;
    for (int w = 0; w < 200 && hit == 0; w++) begin
      #4;
      if (pop_en && int'(pop_cnt) == 10) hit = 1;
      @(negedge clk);
    end
    check("t6_reach_pop10", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    #4;
    check("t6_reset_outs", int'({in_ready, wr_en, wr_row, wr_bank, mrg_bank, mrg_start, pop_en,
                                 pop_cnt, out_valid, out_last, frame_err, busy}), 0);
    pop_q.delete();
    out_q.delete();
    tb_bank = 0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_no_last", n_last, 0);
    #4;
    check("t6_banks_free", int'({busy, in_ready}), 1);
    @(negedge clk);
    clear_stats();
    send_frame(0);
    wait_drain();
    check("t6_start_lat", mrg_start_cyc - last_beat_cyc, 2);
    check("t6_handshakes", n_hs, 32);
    check("t6_lasts", n_last, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
